// File: rtl/cnn_stream_pkg.sv
// Shared types and defaults for the CNN input stream path.
// The marker struct carries the line/frame position flags attached to each pixel.
package cnn_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W = cnt_w(DEF_IMG_W);
  localparam int ROW_W = cnt_w(DEF_IMG_H);

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } marker_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Small synchronous circular buffer with push/pop and an explicit occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module stream_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign full     = (occ == FULL_L);
  assign do_pop   = pop && (occ != '0);
  // A push into a full buffer is only accepted when the head frees a slot this cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[head];

  always_ff @(posedge clk) begin
    if (rest) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (do_push) tail <= nxt(tail);
      if (do_pop)  head <= nxt(head);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + LW'(1);
        2'b01:   occ <= occ - LW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rest && do_push) mem[tail] <= push_data;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rest) !(push && full && !pop));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: credit-based reads into a local buffer, re-presented
// as a valid/ready pixel stream tagged with line/frame position markers.
module fifo_rd_stream
  import cnn_stream_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BUF_DEPTH = 4,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H
) (
  input  logic                              clk,
  input  logic                              rest,
  input  logic                              en,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic [WIDTH-1:0]                  fifo_rd_data,
  input  logic                              fifo_rd_vld,
  output logic [WIDTH-1:0]                  m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_sol,
  output logic                              m_eol,
  output logic                              m_sof,
  output logic                              m_eof,
  output logic                              frame_done,
  output logic [$clog2(BUF_DEPTH+1)-1:0]    buf_level
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [LW:0]   DEPTH_X  = (LW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic             inflight;
  logic             pop;
  logic             push;
  logic [LW:0]      credit_occ;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] head_data;
  marker_t          mark;

  assign pop  = m_valid && m_ready;
  assign push = fifo_rd_vld && !rest;

  // Occupancy the buffer will see once the in-flight read lands, net of this cycle's pop.
  assign credit_occ = {1'b0, buf_level} + {{LW{1'b0}}, inflight} - {{LW{1'b0}}, pop};
  assign fifo_rd_en = en && !fifo_empty && !rest && (credit_occ < DEPTH_X);

  stream_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rest      (rest),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .pop_data  (head_data),
    .occ       (buf_level)
  );

  assign m_valid = (buf_level != '0);
  assign m_data  = m_valid ? head_data : '0;

  always_comb begin
    mark     = '0;
    mark.sol = (col == '0);
    mark.eol = (col == COL_LAST);
    mark.sof = mark.sol && (row == '0);
    mark.eof = mark.eol && (row == ROW_LAST);
  end

  assign m_sol = m_valid && mark.sol;
  assign m_eol = m_valid && mark.eol;
  assign m_sof = m_valid && mark.sof;
  assign m_eof = m_valid && mark.eof;

  always_ff @(posedge clk) begin
    if (rest) begin
      inflight   <= 1'b0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= pop && mark.eof;
      if (pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule
